// File: rtl/water_intake_arbiter.sv
// Four-machine round-robin intake valve arbiter: grant one cycle after a sampled request,
// forced release at MAX_HOLD, GAP_CYCLES of dead-time between owners, fault halts everything.
module water_intake_arbiter #(
   parameter int MAX_HOLD   = 1000,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [3:0] sig_Full,
   input  logic       sig_Fault,
   output logic [3:0] grant,
   output logic [1:0] owner,
   output logic       valve_Open,
   output logic [3:0] timeout_Flag,
   output logic       busy
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP, S_HALT} state_t;

   state_t      r_state;
   logic [3:0]  r_grant;
   logic [1:0]  r_owner;
   logic [1:0]  r_ptr;
   logic [15:0] r_hold;
   logic [7:0]  r_gap;
   logic [3:0]  r_timeout;
   logic        r_valve;
   logic        r_busy;

   logic [1:0]  w_pick;
   logic        w_pick_vld;
   logic        w_rel_req;
   logic        w_rel_full;
   logic        w_rel_max;
   logic        w_release;

   // Scan from the far end so the requester closest to r_ptr is the one that sticks.
   always_comb begin
      logic [1:0] c;
      w_pick     = r_ptr;
      w_pick_vld = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         c = r_ptr + 2'(k);
         if (req[c]) begin
            w_pick     = c;
            w_pick_vld = 1'b1;
         end
      end
   end

   assign w_rel_req  = ~req[r_owner];
   assign w_rel_full = sig_Full[r_owner];
   assign w_rel_max  = (r_hold == 16'(MAX_HOLD - 1));
   assign w_release  = w_rel_req | w_rel_full | w_rel_max;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_grant   <= 4'b0000;
         r_owner   <= 2'd0;
         r_ptr     <= 2'd0;
         r_hold    <= 16'd0;
         r_gap     <= 8'd0;
         r_timeout <= 4'b0000;
         r_valve   <= 1'b0;
         r_busy    <= 1'b0;
      end else if (sig_Fault) begin
         r_state   <= S_HALT;
         r_grant   <= 4'b0000;
         r_valve   <= 1'b0;
         r_timeout <= 4'b0000;
         r_busy    <= 1'b1;
      end else begin
         r_timeout <= 4'b0000;
         case (r_state)
            S_IDLE: begin
               if (w_pick_vld) begin
                  r_state <= S_GRANT;
                  r_grant <= 4'b0001 << w_pick;
                  r_owner <= w_pick;
                  r_valve <= 1'b1;
                  r_hold  <= 16'd0;
                  r_busy  <= 1'b1;
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  r_state <= S_GAP;
                  r_grant <= 4'b0000;
                  r_valve <= 1'b0;
                  r_ptr   <= r_owner + 2'd1;
                  r_gap   <= 8'(GAP_CYCLES);
                  // Timeout pulse only when the hold limit is the sole reason for release.
                  if (w_rel_max && !w_rel_req && !w_rel_full)
                     r_timeout <= 4'b0001 << r_owner;
               end else begin
                  r_hold <= r_hold + 16'd1;
               end
            end
            S_GAP: begin
               if (r_gap <= 8'd1) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap <= r_gap - 8'd1;
               end
            end
            S_HALT: begin
               r_state <= S_GAP;
               r_gap   <= 8'(GAP_CYCLES);
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant        = r_grant;
   assign owner        = r_owner;
   assign valve_Open   = r_valve;
   assign timeout_Flag = r_timeout;
   assign busy         = r_busy;
endmodule

// File: tb/tb_water_intake_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle checked against a behavioural model.
module tb_water_intake_arbiter;
   localparam int MAXH = 5;
   localparam int GAPC = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] sig_Full;
   logic       sig_Fault;
   logic [3:0] grant;
   logic [1:0] owner;
   logic       valve_Open;
   logic [3:0] timeout_Flag;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who holds the valve, for how many cycles, closed cycles still owed.
   bit         m_hold;
   int         m_own;
   int         m_held;
   int         m_dead;
   bit         m_halt;
   int         m_ptr;
   logic [3:0] m_to;

   water_intake_arbiter #(.MAX_HOLD(MAXH), .GAP_CYCLES(GAPC)) dut (
      .clock(clock), .reset(reset), .req(req), .sig_Full(sig_Full), .sig_Fault(sig_Fault),
      .grant(grant), .owner(owner), .valve_Open(valve_Open), .timeout_Flag(timeout_Flag),
      .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit r_req, r_full, r_max;
      bit found;
      int c;
      m_to = 4'b0000;
      if (reset) begin
         m_hold = 0; m_own = 0; m_held = 0; m_dead = 0; m_halt = 0; m_ptr = 0;
      end else if (sig_Fault) begin
         m_hold = 0;
         m_halt = 1;
      end else if (m_halt) begin
         m_halt = 0;
         m_dead = GAPC;
      end else if (m_hold) begin
         r_req  = !req[m_own];
         r_full = sig_Full[m_own];
         r_max  = (m_held == MAXH);
         if (r_req || r_full || r_max) begin
            m_hold = 0;
            m_ptr  = (m_own + 1) % 4;
            m_dead = GAPC;
            if (r_max && !r_req && !r_full) m_to[m_own] = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!found && req[c]) begin
               found  = 1;
               m_own  = c;
               m_hold = 1;
               m_held = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] eg;
      eg = m_hold ? (4'b0001 << m_own) : 4'b0000;
      check("grant", {28'd0, grant}, {28'd0, eg});
      check("owner", {30'd0, owner}, 32'(m_own));
      check("valve", {31'd0, valve_Open}, {31'd0, m_hold});
      check("timeout", {28'd0, timeout_Flag}, {28'd0, m_to});
      check("busy", {31'd0, busy}, {31'd0, (m_hold || m_halt || m_dead > 0)});
      check("onehot", {31'd0, $onehot0(grant)}, 32'd1);
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 4'b0000; sig_Full = 4'b0000; sig_Fault = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int gcnt;
      int to_seen;
      int order[$];
      logic [3:0] prev_g;
      int exp_order[5];

      // Request pattern 1010 from reset: machine 1 first, machine 3 after dead-time.
      do_reset();
      check("rst_grant", {28'd0, grant}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      req = 4'b1010;
      step();
      check("r31_grant1", {28'd0, grant}, 32'b0010);
      check("r31_owner1", {30'd0, owner}, 32'd1);
      req = 4'b1000;
      step();
      check("r31_drop", {28'd0, grant}, 32'd0);
      for (int i = 0; i < GAPC; i++) step();
      step();
      step();
      check("r31_grant3", {28'd0, grant}, 32'b1000);

      // Hold limit: machine 0 kept for exactly MAXH cycles, then a timeout pulse.
      do_reset();
      req = 4'b0001;
      gcnt = 0; to_seen = 0;
      for (int i = 0; i < MAXH + 3; i++) begin
         step();
         if (grant == 4'b0001) gcnt++;
         if (timeout_Flag == 4'b0001) to_seen++;
      end
      check("r32_hold_len", 32'(gcnt), 32'(MAXH));
      check("r32_timeout", 32'(to_seen), 32'd1);
      for (int i = 0; i < 4; i++) step();
      check("r32_regrant", {28'd0, grant}, 32'b0001);

      // All request, each owner fills after 3 cycles: strict rotation.
      do_reset();
      req = 4'b1111;
      prev_g = 4'b0000;
      for (int i = 0; i < 200 && order.size() < 5; i++) begin
         sig_Full = (m_hold && m_held == 3) ? (4'b0001 << m_own) : 4'b0000;
         step();
         if (grant != 4'b0000 && prev_g == 4'b0000) order.push_back(int'(owner));
         prev_g = grant;
      end
      sig_Full = 4'b0000;
      exp_order = '{0, 1, 2, 3, 0};
      check("r33_count", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5 && i < order.size(); i++)
         check("r33_order", 32'(order[i]), 32'(exp_order[i]));

      // Fault mid-grant for 4 cycles.
      do_reset();
      req = 4'b0001;
      step();
      step();
      sig_Fault = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("r34_valve", {31'd0, valve_Open}, 32'd0);
         check("r34_busy", {31'd0, busy}, 32'd1);
      end
      sig_Fault = 1'b0;
      for (int i = 0; i < GAPC + 2; i++) step();
      check("r34_resume", {28'd0, grant}, 32'b0001);

      // Request withdrawn on the last allowed cycle: no timeout.
      do_reset();
      req = 4'b0001;
      to_seen = 0;
      for (int i = 0; i < MAXH; i++) begin
         if (i == MAXH) req = 4'b0000;
         step();
         if (i == MAXH - 1) req = 4'b0000;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         if (timeout_Flag != 4'b0000) to_seen++;
      end
      check("r35_no_timeout", 32'(to_seen), 32'd0);

      // Reset during grant.
      do_reset();
      req = 4'b0100;
      step();
      step();
      reset = 1'b1;
      step();
      check("r36_grant0", {28'd0, grant}, 32'd0);
      check("r36_valve0", {31'd0, valve_Open}, 32'd0);
      check("r36_busy0", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      step();
      check("r36_regrant", {28'd0, grant}, 32'b0100);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         sig_Full = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
         if (sig_Fault) sig_Fault = ($urandom_range(0, 3) != 0);
         else           sig_Fault = ($urandom_range(0, 59) == 0);
         reset = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
